// File: rtl/dir_input_if.sv
// Direction-input bus: raw buttons and game-step tick in, committed
// direction strobes and status out.
interface dir_input_if;
  logic [3:0] btn;
  logic       step;
  logic [3:0] mov;
  logic [1:0] dir;
  logic       pending_valid;

  // Master drives buttons and the step tick and observes the result.
  modport master (
    output btn,
    output step,
    input  mov,
    input  dir,
    input  pending_valid
  );

  // Slave is the direction-input block itself.
  modport slave (
    input  btn,
    input  step,
    output mov,
    output dir,
    output pending_valid
  );
endinterface

// File: rtl/dir_input.sv
// Snake direction input stage: synchronises and debounces four raw
// buttons, turns presses into at most one queued turn, and commits that
// turn on the game-step tick as a one-cycle one-hot mov strobe.
// Direction encoding: 0 right, 1 down, 2 left, 3 up.
module dir_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic        clk,
  input logic        rst,
  dir_input_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]            syncMeta_q;
  logic [3:0]            sync_q;
  logic [3:0]            deb_q, deb_d;
  logic [3:0]            debDly_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]            dir_q, dir_d;
  logic [1:0]            pend_q, pend_d;
  logic                  pendValid_q, pendValid_d;
  logic [3:0]            mov_q, mov_d;

  logic [3:0]            press;
  logic                  pressFound;
  logic [1:0]            pressDir;
  logic                  commit;
  logic [1:0]            refDir;
  logic                  accept;

  // Two-flop synchroniser bringing the asynchronous buttons into clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncMeta_q <= '0;
      sync_q     <= '0;
    end else begin
      syncMeta_q <= bus.btn;
      sync_q     <= syncMeta_q;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Debounced levels, their delayed copy for edge detection, and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q    <= '0;
      debDly_q <= '0;
      cnt_q    <= '0;
    end else begin
      deb_q    <= deb_d;
      debDly_q <= deb_q;
      cnt_q    <= cnt_d;
    end
  end

  // Pick the lowest-index rising press; releases never count as events.
  always_comb begin
    press      = deb_q & ~debDly_q;
    pressFound = 1'b1;
    pressDir   = 2'd0;
    if (press[0]) begin
      pressDir = 2'd0;
    end else if (press[1]) begin
      pressDir = 2'd1;
    end else if (press[2]) begin
      pressDir = 2'd2;
    end else if (press[3]) begin
      pressDir = 2'd3;
    end else begin
      pressFound = 1'b0;
    end
  end

  // Commit the pending turn on step and decide whether the press is queued.
  always_comb begin
    commit      = bus.step & pendValid_q;
    refDir      = commit ? pend_q : dir_q;
    accept      = pressFound
                  && (pressDir != refDir)
                  && (pressDir != (refDir ^ 2'b10))
                  && !(pendValid_q && !bus.step);
    dir_d       = dir_q;
    mov_d       = '0;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    if (commit) begin
      dir_d       = pend_q;
      mov_d       = 4'b0001 << pend_q;
      pendValid_d = 1'b0;
    end
    if (accept) begin
      pend_d      = pressDir;
      pendValid_d = 1'b1;
    end
  end

  // Committed direction, pending turn and the mov strobe register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q       <= 2'd0;
      pend_q      <= 2'd0;
      pendValid_q <= 1'b0;
      mov_q       <= '0;
    end else begin
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
      mov_q       <= mov_d;
    end
  end

  assign bus.mov           = mov_q;
  assign bus.dir           = dir_q;
  assign bus.pending_valid = pendValid_q;

endmodule

// File: tb/tb_dir_input.sv
// Testbench for dir_input: directed scenarios followed by random button
// and step traffic, all checked every cycle against a behavioural model.
module tb_dir_input;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dir_input_if dutIf ();

  dir_input #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dutIf.slave)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int asserts  = 0;
  int failures = 0;

  // Behavioural model state: recent button samples (index 0 newest),
  // debounced levels, committed direction and the queued turn.
  logic [3:0] hist [DC+1];
  logic [3:0] mDeb, mDebPrev, mMov;
  logic [1:0] mDir, mPend;
  logic       mPv;

  task automatic modelReset();
    for (int j = 0; j <= DC; j++) hist[j] = 4'b0000;
    mDeb = 0; mDebPrev = 0; mMov = 0; mDir = 0; mPend = 0; mPv = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic modelEdge(input logic [3:0] b, input logic s);
    logic [3:0] press, newDeb;
    logic [1:0] d, r;
    logic       found, commit, accept, allDiffer;
    press = mDeb & ~mDebPrev;
    found = 1'b0;
    d     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) begin
        found = 1'b1;
        d     = 2'(i);
      end
    end
    commit = s && mPv;
    r      = commit ? mPend : mDir;
    accept = found && (d != r) && (d != (r ^ 2'b10)) && !(mPv && !s);
    // A button flips once the DC synchronised samples seen (two edges old
    // and older) all disagree with its current debounced level.
    newDeb = mDeb;
    for (int bi = 0; bi < 4; bi++) begin
      allDiffer = 1'b1;
      for (int j = 1; j <= DC; j++) begin
        if (hist[j][bi] == mDeb[bi]) allDiffer = 1'b0;
      end
      if (allDiffer) newDeb[bi] = ~mDeb[bi];
    end
    for (int j = DC; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = b;
    mMov = commit ? (4'b0001 << mPend) : 4'b0000;
    if (commit) begin
      mDir = mPend;
      mPv  = 1'b0;
    end
    if (accept) begin
      mPend = d;
      mPv   = 1'b1;
    end
    mDebPrev = mDeb;
    mDeb     = newDeb;
  endtask

  task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    asserts++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, "_mov"}, dutIf.mov, mMov);
    checkOne({tag, "_dir"}, {2'b00, dutIf.dir}, {2'b00, mDir});
    checkOne({tag, "_pv"}, {3'b000, dutIf.pending_valid}, {3'b000, mPv});
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic applyStimulus(input logic [3:0] b, input logic s);
    dutIf.btn  = b;
    dutIf.step = s;
    modelEdge(b, s);
    @(posedge clk);
    #1;
    checkOutput("cycle");
    dutIf.step = 1'b0;
  endtask

  task automatic holdBtn(input logic [3:0] b, input int n);
    for (int c = 0; c < n; c++) applyStimulus(b, 1'b0);
  endtask

  // Assert reset between clock edges and expect outputs to clear at once.
  task automatic doReset();
    #2;
    rst        = 1'b0;
    dutIf.btn  = 4'b0000;
    dutIf.step = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_async");
    checkOne("reset_async_mov0", dutIf.mov, 4'b0000);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold");
    end
    rst = 1'b1;
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    int         riseAt;
    logic [3:0] rb;
    int         hold;
    logic       s, lastStep;

    dutIf.btn  = 4'b0000;
    dutIf.step = 1'b0;
    modelReset();
    #1;
    checkOutput("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle after reset: nothing should move.
    holdBtn(4'b0000, 20);
    checkOne("idle_dir", {2'b00, dutIf.dir}, 4'b0000);

    // Down press: pending after DC+3 edges, then committed by step.
    riseAt = -1;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(4'b0010, 1'b0);
      if (riseAt < 0 && dutIf.pending_valid === 1'b1) riseAt = c;
    end
    checkInt("pv_latency", riseAt, DC + 3);
    holdBtn(4'b0000, 8);
    applyStimulus(4'b0000, 1'b1);
    checkOne("commit_down_mov", dutIf.mov, 4'b0010);
    checkOne("commit_down_dir", {2'b00, dutIf.dir}, 4'b0001);
    applyStimulus(4'b0000, 1'b0);
    checkOne("commit_down_mov_once", dutIf.mov, 4'b0000);

    // From right: left is a reversal, right is a repeat.
    doReset();
    holdBtn(4'b0100, 8);
    holdBtn(4'b0000, 8);
    checkOne("reverse_rejected", {3'b000, dutIf.pending_valid}, 4'b0000);
    holdBtn(4'b0001, 8);
    holdBtn(4'b0000, 8);
    checkOne("repeat_rejected", {3'b000, dutIf.pending_valid}, 4'b0000);

    // Short up glitches are filtered; a full-length pulse is accepted.
    for (int p = 0; p < 4; p++) begin
      holdBtn(4'b1000, DC - 1);
      holdBtn(4'b0000, DC - 1);
    end
    holdBtn(4'b0000, 6);
    checkOne("glitch_filtered", {3'b000, dutIf.pending_valid}, 4'b0000);
    holdBtn(4'b1000, DC);
    holdBtn(4'b0000, 4);
    checkOne("pulse_accepted", {3'b000, dutIf.pending_valid}, 4'b0001);
    applyStimulus(4'b0000, 1'b1);
    checkOne("commit_up_mov", dutIf.mov, 4'b1000);

    // Second press while a turn is pending is dropped.
    doReset();
    holdBtn(4'b0010, 8);
    holdBtn(4'b0000, 8);
    holdBtn(4'b0100, 8);
    holdBtn(4'b0000, 8);
    applyStimulus(4'b0000, 1'b1);
    checkOne("only_first_pends", dutIf.mov, 4'b0010);
    checkOne("only_first_pv", {3'b000, dutIf.pending_valid}, 4'b0000);

    // A press accepted on the same edge that commits the pending turn.
    doReset();
    holdBtn(4'b0010, 8);
    holdBtn(4'b0000, 8);
    holdBtn(4'b0100, DC + 2);
    applyStimulus(4'b0100, 1'b1);
    checkOne("coincide_dir", {2'b00, dutIf.dir}, 4'b0001);
    checkOne("coincide_pv", {3'b000, dutIf.pending_valid}, 4'b0001);
    holdBtn(4'b0000, 6);
    applyStimulus(4'b0000, 1'b1);
    checkOne("coincide_next_mov", dutIf.mov, 4'b0100);

    // Simultaneous presses: lowest index wins; then reset mid-debounce.
    doReset();
    holdBtn(4'b1010, 8);
    holdBtn(4'b0000, 8);
    applyStimulus(4'b0000, 1'b1);
    checkOne("arb_down_wins", dutIf.mov, 4'b0010);
    holdBtn(4'b1000, DC);
    doReset();
    for (int c = 0; c < 20; c++) applyStimulus(4'b0000, (c % 5) == 4);
    checkOne("post_reset_pv", {3'b000, dutIf.pending_valid}, 4'b0000);

    // Random button patterns and sparse step pulses.
    rb       = 4'b0000;
    hold     = 0;
    lastStep = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 0) rb = 4'(4'b0001 << $urandom_range(0, 3));
        else                            rb = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) rb = 4'b0000;
        hold = $urandom_range(1, 12);
      end
      hold--;
      s = !lastStep && ($urandom_range(0, 5) == 0);
      applyStimulus(rb, s);
      lastStep = s;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/dir_input.md
Name:
dir_input

Overview:
- Upstream stage of the snake drawer: converts four raw, asynchronous direction buttons into the drawer's `mov[3:0]` direction strobes.
- Synchronises and debounces each button, then edge-detects presses and rejects 180° reversals and repeat presses.
- Holds one pending turn and commits it only on the game-step tick, so at most one turn is applied per snake step.
- Bit/direction mapping matches the drawer: 0 = right (00), 1 = down (01), 2 = left (10), 3 = up (11).

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised level must differ from the debounced level before it is accepted (10 ms at 50 MHz); must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- btn  input  4  raw buttons, active-high, asynchronous to clk; bit i = direction i.
- step  input  1  game-step tick, one-cycle pulse, synchronous to clk.
- mov  output  4  one-hot, one-cycle strobe of the newly committed direction; 0 otherwise.
- dir  output  2  currently committed direction.
- pending_valid  output  1  a turn is queued awaiting `step`.

Behaviour:
- Reset (`rst` = 0, asynchronous, immediate, including mid-operation) clears:
  - `mov` = 0, `dir` = 00 (right), `pending_valid` = 0;
  - pending direction = 00;
  - all sync flops, debounced levels, edge-detect flops and counters = 0.
- Synchroniser: 2-flop synchroniser per button, giving `sync[i]`.
- Debounce, per button:
  - If `sync[i]` == `deb[i]`, `cnt[i]` <= 0.
  - Otherwise `cnt[i]` increments.
  - When `cnt[i]` == DEBOUNCE_CYCLES-1 and `sync[i]` still differs: `deb[i]` <= `sync[i]` and `cnt[i]` <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
  - Releases are debounced identically but generate no event.
- Press detect: `press[i]` = `deb[i]` & ~`deb_d[i]` (`deb_d` is the one-cycle-delayed `deb`).
- Arbitration: if several `press` bits are set in one cycle, the lowest index wins (right > down > left > up); the others are discarded.
- Acceptance of the winning press with direction d, checked against reference direction R:
  - R = the direction being committed this cycle if `step` & `pending_valid`, else `dir`.
  - Rejected if d == R (repeat).
  - Rejected if d == R ^ 2'b10 (reversal).
  - Rejected if `pending_valid` stays 1 this cycle, i.e. a pending turn exists and `step` is not committing it.
  - Otherwise: pending <= d, `pending_valid` <= 1.
- Commit, at the clk edge where `step` = 1 and `pending_valid` = 1:
  - `dir` <= pending, `mov` <= onehot(pending) for exactly one cycle, `pending_valid` <= 0.
  - If a press is accepted in that same cycle, `pending_valid` <= 1 instead.
- `step` with `pending_valid` = 0: no change, `mov` stays 0.
- `mov` is never multi-hot and never asserted two consecutive cycles.
- Latency: `btn` rise to `pending_valid` = 2 sync + DEBOUNCE_CYCLES + 1 edge-detect/accept = DEBOUNCE_CYCLES+3 edges; `step` to `mov`/`dir` = 1 edge.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset then idle 20 cycles -> `dir` = 00, `mov` = 0, `pending_valid` = 0 throughout.
- `btn` = 0010 held 10 cycles -> `pending_valid` rises 7 edges after `btn`; next `step` -> `mov` = 0010 for 1 cycle, `dir` = 01, `pending_valid` = 0.
- With `dir` = 00, press left (0100) cleanly -> rejected, `pending_valid` stays 0; press right (0001) -> rejected as repeat.
- `btn[3]` pulses of 3 cycles repeated -> `deb` never rises, no pending; a 4-cycle stable pulse -> accepted, pending = 11.
- Press down, then press left before `step` -> only down pends; `step` -> `dir` = 01; left pressed so its edge coincides with a `step` committing down -> `dir` = 01 and left pending together.
- Simultaneous `btn` = 1010 from `dir` = 00 -> down wins, pending = 01; assert `rst` low mid-debounce of a second press -> all outputs 0 at once, no `mov` after release.
